mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO; owns the HI/LO registers; serves MFHI/MFLO reads.
- Models fixed result latency with a busy counter.
- Raises a stall request so the D-stage HI/LO-using instruction waits.
- Honours the exception flush so a faulting or interrupted instruction never changes HI/LO.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  4  E-stage MDU op code (`MDU_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU)
- start  in  1  E-stage valid strobe for op
- flush  in  1  exception/interrupt request this cycle; suppresses acceptance of op
- a  in  32  rs operand
- b  in  32  rt operand
- d_is_md  in  1  D-stage instruction is any MDU op
- busy  out  1  multi-cycle operation in flight
- stall  out  1  d_is_md & (busy | accepted start of MULT/DIV-class op)
- out  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, state=IDLE, counter=0, busy=0. Reset during BUSY aborts the operation; no HI/LO write.
- Accept rule: an op is accepted when start=1 and flush=0. With flush=1 nothing is written and no operation starts.
- States are IDLE and BUSY.
- IDLE, accepted MULT-class op:
  - Compute the 64-bit product combinationally and latch it into result regs.
  - counter=MULT_CYCLES, go to BUSY; busy=1 from the next cycle.
- IDLE, accepted DIV-class op: same, with counter=DIV_CYCLES.
- BUSY:
  - counter decrements each cycle.
  - In the cycle counter==1: {HI,LO} <= result, state -> IDLE.
  - busy is high for exactly N cycles; new HI/LO are visible on out the cycle after busy falls.
- Start of a MULT/DIV-class op while BUSY is ignored. Upstream stall guarantees it never occurs; this is an assertion in the bench.
- MTHI/MTLO, accepted: HI (or LO) <= a at the next edge, in either state. A completing operation in the same or a later cycle overwrites both HI and LO.
- MFHI/MFLO: out is purely combinational from current HI/LO. MFHI/MFLO have no side effects.
- Arithmetic:
  - MULT: signed 32x32 -> 64. MULTU: unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: HI/LO keep old values, but latency is still DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- stall is combinational. It is asserted in the acceptance cycle itself (start & ~flush & MULT/DIV-class) and throughout BUSY, whenever d_is_md=1.
- flush never aborts an in-flight operation (it was committed when accepted).

Optional Feature:
- MDU_MADD_EN defined:
  - MADD/MADDU/MSUB/MSUBU are accepted with MULT_CYCLES latency.
  - Result = {HI,LO} ± product, with HI/LO sampled at acceptance; wrap modulo 2^64.
- MDU_MADD_EN undefined: those codes decode as MDU_NONE (no start, no stall, out=0).

Decomposition:
- Shared header: `MDU_*` op codes (4-bit) and the state encodings, alongside the existing `JUMP_*` defines.
- One sub-module is natural: mdu_calc, a combinational 64-bit result generator taking op, a, b, hi, lo. It keeps the sequencer to state, counter and registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, start=1, d_is_md=1 -> stall=1 in cycle 0; busy=1 for exactly 5 cycles; then MFHI out=0xFFFFFFFF, MFLO out=0xFFFFFFFA.
- DIVU a=7, b=2 -> busy 10 cycles, then HI=1, LO=3. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI a=0x12345678 with flush=1 -> HI unchanged (0). Repeat with flush=0 -> MFHI=0x12345678 next cycle.
- DIV b=0 after MTLO 0xAA -> busy 10 cycles, LO stays 0xAA.
- Reset asserted mid-BUSY (cycle 3 of MULT 5x5) -> busy=0 next cycle; HI=LO=0; no later write.
- With MDU_MADD_EN: HI:LO=0x0:0xFFFFFFFF, MADDU a=1, b=1 -> HI=1, LO=0. Without MDU_MADD_EN: same stimulus -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU op codes, FSM states and op-class helpers.
// Optional macro: MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU class.
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int CNT_W = 4;

  function automatic logic is_mul(logic [3:0] op);
    logic m;
    m = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    m = m || (op == MDU_MADD) || (op == MDU_MADDU)
          || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return m;
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_calc.sv
// Combinational 64-bit {HI,LO} result generator for the MDU.
// Ports: op, a, b, current hi/lo in; res = {HI,LO} out. Macro: MDU_MADD_EN.
module mdu_sequencer_calc
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    // Signed divide on magnitudes avoids the INT_MIN / -1 overflow case.
    sgn      = (op == MDU_DIV);
    dvd      = (sgn && a[31]) ? -a : a;
    dvs      = (sgn && b[31]) ? -b : b;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    q_mag    = dvd / dvs_safe;
    r_mag    = dvd % dvs_safe;
    quo      = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem      = (sgn && a[31]) ? -r_mag : r_mag;
    res      = {hi, lo};
    unique case (1'b1)
      op == MDU_MULT:  res = prod_s;
      op == MDU_MULTU: res = prod_u;
      // Divide by zero re-writes the HI/LO sampled at acceptance.
      is_div(op):      res = (dvs == 32'd0) ? {hi, lo} : {rem, quo};
`ifdef MDU_MADD_EN
      op == MDU_MADD:  res = {hi, lo} + prod_s;
      op == MDU_MADDU: res = {hi, lo} + prod_u;
      op == MDU_MSUB:  res = {hi, lo} - prod_s;
      op == MDU_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:         res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV sequencer owning HI/LO, with D-stage stall request.
// Ports: op/start/flush/a/b/d_is_md in; busy/stall/out. Macro: MDU_MADD_EN.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] out
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       res_q, res_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [63:0]       calc;
  logic              acc;
  logic              acc_md;
  logic              go;
  logic              done;

  mdu_sequencer_calc u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc)
  );

  assign acc    = start & ~flush;
  assign acc_md = acc & (is_mul(op) | is_div(op));
  assign go     = acc_md & (state_q == ST_IDLE);
  assign done   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_BUSY;
      ST_BUSY: if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (go) begin
      res_d = calc;
      cnt_d = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (acc && op == MDU_MTHI) hi_d = a;
    if (acc && op == MDU_MTLO) lo_d = a;
    // Completion wins over a same-cycle MTHI/MTLO.
    if (done) {hi_d, lo_d} = res_q;
  end

  always_comb begin
    busy  = (state_q == ST_BUSY);
    stall = d_is_md & (busy | acc_md);
    out   = 32'd0;
    if (op == MDU_MFHI) out = hi_q;
    if (op == MDU_MFLO) out = lo_q;
  end

endmodule
